spn_cipher_iter: RTL

Parametrised, iterative multi-round SPN cipher engine for the secure sensor link. It replaces the fixed 8-bit single-round datapath with configurable width and round count. It uses a valid/ready handshake on both sides and an XOR-folded integrity byte. It sits between the sensor sample packer and the link framer, and executes one round per clock.

---
 rtl/spn_cipher_iter_if.sv | 36 +++
 rtl/spn_cipher_iter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spn_cipher_iter_if.sv
// Valid/ready bus for the iterative SPN cipher engine.
// The upstream block producer and downstream consumer drive opposite sides.
// Optional macro SPN_DECRYPT_EN adds the per-block mode bit (0=encrypt, 1=decrypt).
interface spn_cipher_iter_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] key;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] cipher_out;
  logic [7:0]       checksum;
`ifdef SPN_DECRYPT_EN
  logic             mode;

  modport master (
    output in_valid, data_in, key, mode, out_ready,
    input  in_ready, out_valid, cipher_out, checksum
  );
  modport slave (
    input  in_valid, data_in, key, mode, out_ready,
    output in_ready, out_valid, cipher_out, checksum
  );
`else
  modport master (
    output in_valid, data_in, key, out_ready,
    input  in_ready, out_valid, cipher_out, checksum
  );
  modport slave (
    input  in_valid, data_in, key, out_ready,
    output in_ready, out_valid, cipher_out, checksum
  );
`endif
endinterface

// File: rtl/spn_cipher_iter.sv
// Iterative SPN cipher engine, one round per clock, valid/ready on both sides.
// Result carries an XOR-folded integrity byte of (cipher_out ^ latched key).
// Optional macro SPN_DECRYPT_EN adds a decrypt path selected per block by bus.mode.
module spn_cipher_iter #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ROUNDS = 4
) (
  input logic              clk,
  input logic              rst,
  spn_cipher_iter_if.slave bus
);

  localparam int unsigned Half      = WIDTH / 2;
  localparam logic [3:0]  LastRnd   = 4'(ROUNDS - 1);
  localparam logic [3:0]  WhitenRnd = 4'(ROUNDS);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           fsm_q, fsm_d;
  logic [WIDTH-1:0] blk_q, blk_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic [WIDTH-1:0] cipher_q, cipher_d;
  logic [7:0]       checksum_q, checksum_d;
  logic [3:0]       rnd_q, rnd_d;
  logic             out_valid_q, out_valid_d;

  logic             in_ready;
  logic             accept;
  logic [3:0]       round_idx;
  logic [WIDTH-1:0] round_key;
  logic [WIDTH-1:0] load_blk;
  logic [WIDTH-1:0] round_out;
  logic [WIDTH-1:0] final_out;
`ifdef SPN_DECRYPT_EN
  logic             mode_q, mode_d;
`endif

  function automatic logic [WIDTH-1:0] rol(logic [WIDTH-1:0] v, logic [3:0] amt);
    logic [2*WIDTH-1:0] dbl;
    int unsigned        sh;
    sh  = 32'(amt) % WIDTH;
    dbl = {v, v} << sh;
    return dbl[2*WIDTH-1:WIDTH];
  endfunction

  function automatic logic [3:0] sbox4(logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hE;  4'h1: y = 4'h4;  4'h2: y = 4'hD;  4'h3: y = 4'h1;
      4'h4: y = 4'h2;  4'h5: y = 4'hF;  4'h6: y = 4'hB;  4'h7: y = 4'h8;
      4'h8: y = 4'h3;  4'h9: y = 4'hA;  4'hA: y = 4'h6;  4'hB: y = 4'hC;
      4'hC: y = 4'h5;  4'hD: y = 4'h9;  4'hE: y = 4'h0;  default: y = 4'h7;
    endcase
    return y;
  endfunction

  function automatic logic [WIDTH-1:0] sbox_layer(logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] y;
    y = '0;
    for (int n = 0; n < int'(WIDTH / 4); n++) y[4*n +: 4] = sbox4(x[4*n +: 4]);
    return y;
  endfunction

  // Low half goes to the even-from-top bits, high half interleaves below it.
  function automatic logic [WIDTH-1:0] perm(logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] y;
    y = '0;
    for (int i = 0; i < int'(Half); i++) begin
      y[WIDTH-1-2*i] = x[i];
      y[WIDTH-2-2*i] = x[Half+i];
    end
    return y;
  endfunction

  function automatic logic [7:0] fold(logic [WIDTH-1:0] x);
    logic [7:0] f;
    f = '0;
    for (int b = 0; b < int'(WIDTH / 8); b++) f ^= x[8*b +: 8];
    return f;
  endfunction

`ifdef SPN_DECRYPT_EN
  function automatic logic [3:0] inv_sbox4(logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hE;  4'h1: y = 4'h3;  4'h2: y = 4'h4;  4'h3: y = 4'h8;
      4'h4: y = 4'h1;  4'h5: y = 4'hC;  4'h6: y = 4'hA;  4'h7: y = 4'hF;
      4'h8: y = 4'h7;  4'h9: y = 4'hD;  4'hA: y = 4'h9;  4'hB: y = 4'h6;
      4'hC: y = 4'hB;  4'hD: y = 4'h2;  4'hE: y = 4'h0;  default: y = 4'h5;
    endcase
    return y;
  endfunction

  function automatic logic [WIDTH-1:0] inv_sbox_layer(logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] y;
    y = '0;
    for (int n = 0; n < int'(WIDTH / 4); n++) y[4*n +: 4] = inv_sbox4(x[4*n +: 4]);
    return y;
  endfunction

  function automatic logic [WIDTH-1:0] inv_perm(logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] x;
    x = '0;
    for (int i = 0; i < int'(Half); i++) begin
      x[i]      = y[WIDTH-1-2*i];
      x[Half+i] = y[WIDTH-2-2*i];
    end
    return x;
  endfunction
`endif

  // Handshake: ready only when idle or when the held result retires this cycle.
  always_comb begin
    in_ready = !rst && ((fsm_q == StIdle) || ((fsm_q == StDone) && bus.out_ready));
    accept   = bus.in_valid && in_ready;
  end

  // Round datapath; decrypt walks the round keys backwards and pre-whitens on load.
  always_comb begin
    round_idx = rnd_q;
    load_blk  = bus.data_in;
`ifdef SPN_DECRYPT_EN
    if (mode_q) round_idx = LastRnd - rnd_q;
    if (bus.mode) load_blk = bus.data_in ^ rol(bus.key, WhitenRnd);
`endif
    round_key = rol(key_q, round_idx);
    round_out = perm(sbox_layer(blk_q ^ round_key));
    final_out = round_out ^ rol(key_q, WhitenRnd);
`ifdef SPN_DECRYPT_EN
    if (mode_q) begin
      round_out = inv_sbox_layer(inv_perm(blk_q)) ^ round_key;
      final_out = round_out;
    end
`endif
  end

  // Next-state for the control FSM and all datapath registers.
  always_comb begin
    fsm_d       = fsm_q;
    blk_d       = blk_q;
    key_d       = key_q;
    cipher_d    = cipher_q;
    checksum_d  = checksum_q;
    rnd_d       = rnd_q;
    out_valid_d = out_valid_q;
`ifdef SPN_DECRYPT_EN
    mode_d      = mode_q;
`endif
    unique case (fsm_q)
      StRun: begin
        blk_d = round_out;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == LastRnd) begin
          cipher_d    = final_out;
          checksum_d  = fold(final_out ^ key_q);
          out_valid_d = 1'b1;
          fsm_d       = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = StIdle;
        end
      end
      default: ;
    endcase
    // Accept overrides the idle/retire path, giving back-to-back from StDone.
    if (accept) begin
      blk_d = load_blk;
      key_d = bus.key;
      rnd_d = 4'd0;
      fsm_d = StRun;
`ifdef SPN_DECRYPT_EN
      mode_d = bus.mode;
`endif
    end
  end

  // State registers with synchronous reset; reset drops any in-flight block.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= StIdle;
      blk_q       <= '0;
      key_q       <= '0;
      cipher_q    <= '0;
      checksum_q  <= '0;
      rnd_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef SPN_DECRYPT_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      blk_q       <= blk_d;
      key_q       <= key_d;
      cipher_q    <= cipher_d;
      checksum_q  <= checksum_d;
      rnd_q       <= rnd_d;
      out_valid_q <= out_valid_d;
`ifdef SPN_DECRYPT_EN
      mode_q      <= mode_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.cipher_out = cipher_q;
  assign bus.checksum   = checksum_q;

endmodule
